// File: rtl/ttl_piso_shift_tx.sv
// Parallel-in/serial-out link transmitter with clock inhibit and inter-word gap.
// Ports: clk, clr_n, load_valid/load_data/load_ready, shift_ce, hold, ser_out, bit_strobe, done, busy, bits_left.
module ttl_piso_shift_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_ce,
  input  logic             hold,
  output logic             ser_out,
  output logic             bit_strobe,
  output logic             done,
  output logic             busy,
  output logic [4:0]       bits_left
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam logic [4:0] W5 = 5'(WIDTH);
  localparam logic [7:0] G8 = 8'(GAP_CYCLES);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [7:0]       gap_cnt;

  assign load_ready = (state == IDLE) && !hold;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      sr         <= '0;
      gap_cnt    <= '0;
      ser_out    <= 1'b0;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      bits_left  <= '0;
    end else begin
      // strobe and done are single-cycle unless re-asserted below
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_valid && !hold) begin
            sr        <= load_data;
            bits_left <= W5;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_ce && !hold) begin
            bit_strobe <= 1'b1;
            bits_left  <= bits_left - 5'd1;
            if (MSB_FIRST) begin
              ser_out <= sr[WIDTH-1];
              sr      <= sr << 1;
            end else begin
              ser_out <= sr[0];
              sr      <= sr >> 1;
            end
            if (bits_left == 5'd1) begin
              done <= 1'b1;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= G8;
                state   <= GAP;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end
        GAP: begin
          if (!hold) begin
            gap_cnt <= gap_cnt - 8'd1;
            if (gap_cnt == 8'd1) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
